csr_reg_bank: RTL and testbench
===============================

Name: csr_reg_bank

Overview:
Parametrised bank of NUM_REGS config/status registers, each with per-bit access types: RW, WO, RO, RC (clear-on-read), W1C and PULSE. Adds byte-strobed writes, indexed addressing, sticky hardware event capture that never drops events, a registered read-response handshake and an aggregated interrupt. Sits between the AXI-Lite memory-model front end and the vertex/fragment logic blocks, replacing per-register hand-instantiated slices.

Parameters:
DATA_WIDTH, 32, register width in bits (multiple of 8)
NUM_REGS, 8, number of registers in the bank
ADDR_WIDTH, 3, word-index width, >= clog2(NUM_REGS)
RW_MASK, '0, NUM_REGS*DATA_WIDTH flat vector; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
WO_MASK, '0, write-only bits (same layout)
RO_MASK, '0, read-only live hardware bits
RC_MASK, '0, sticky hardware-set, clear-on-read bits
W1C_MASK, '0, sticky hardware-set, write-1-to-clear bits
PULSE_MASK, '0, self-clearing single-cycle command bits
IRQ_MASK, '0, subset of W1C_MASK contributing to irq

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
wr_req  input  1  write strobe, one register per cycle
wr_addr  input  ADDR_WIDTH  word index
wr_data  input  DATA_WIDTH  write data
wr_strb  input  DATA_WIDTH/8  byte enables
rd_req  input  1  read strobe
rd_addr  input  ADDR_WIDTH  word index
rd_valid  output  1  read response valid, one cycle
rd_data  output  DATA_WIDTH  read data
rd_err  output  1  set with rd_valid when rd_addr >= NUM_REGS
hw_ro_in  input  NUM_REGS*DATA_WIDTH  live RO values
hw_set_in  input  NUM_REGS*DATA_WIDTH  event pulses setting RC/W1C bits
cfg_out  output  NUM_REGS*DATA_WIDTH  RW/WO/PULSE bit values to logic (other bit positions 0)
irq  output  1  OR of (stored W1C bits & IRQ_MASK), registered

Behaviour:
- Reset: all stored bits 0; rd_valid=0, rd_data=0, rd_err=0, irq=0, cfg_out=0. A request in the reset cycle is dropped.
- Write, accepted at edge N: effective mask = access mask & byte-expanded wr_strb. RW/WO/PULSE bits take wr_data; a W1C bit with wr_data=1 clears; RO/RC bits are unaffected. Results are visible on cfg_out from cycle N+1.
- wr_addr >= NUM_REGS: write silently ignored.
- PULSE bit written 1: high on cfg_out for exactly one cycle (N+1), then 0 with no write required. Back-to-back writes give consecutive pulse cycles.
- RC/W1C set: hw_set_in bit=1 at edge sets the stored bit (sticky).
- Set-wins rule: on the same cycle as a W1C clear or RC read, a hw_set_in bit leaves the stored bit set. No event is lost.
- Read, rd_req at edge N: rd_valid=1 at N+1 for one cycle.
  - rd_data = pre-edge stored value of RW|RC|W1C bits, plus hw_ro_in sampled at edge N for RO bits.
  - WO and PULSE bits read 0.
  - RC bits of the read register are cleared at edge N, except for bits being set that same cycle.
- rd_addr >= NUM_REGS: rd_data=0, rd_err=1, no side effects.
- Simultaneous wr_req and rd_req to the same register: the read returns the pre-write value, and both take effect.
- rd_valid is 0 in every cycle without a preceding rd_req. Reads may be issued every cycle.
- irq: registered, so it updates one cycle after the stored W1C bits change.
- Overlapping masks for the same bit are illegal. Checked by an elaboration-time assertion.

Decomposition:
- Package csr_reg_bank_pkg: access-type enum (ACC_RW, ACC_WO, ACC_RO, ACC_RC, ACC_W1C, ACC_PULSE), a strobe-to-bitmask expansion function, and a mask-overlap check function.
- Sub-module csr_reg_bank_slice: one register, next-state logic plus flops, generated NUM_REGS times. The top level holds address decode, the read mux/response register and the irq reduction.

Test Plan:
- Reset, then read all 8 regs -> rd_valid one cycle later each, rd_data=0, rd_err=0; read index 9 with ADDR_WIDTH=4 -> rd_err=1, rd_data=0.
- Reg0 RW_MASK=0xFFFF_FFFF: write 0xA5A5_A5A5 with strb=4'b0101 over prior 0x1111_1111 -> read 0x11A5_11A5.
- Reg1 bit0 PULSE: write 0x1 -> cfg_out bit high exactly one cycle, then 0; read -> 0x0.
- Reg2 bit3 W1C+IRQ: hw_set pulse -> irq=1; write 0x8 with a same-cycle hw_set -> bit stays set, irq stays 1; write 0x8 alone -> cleared, irq=0 next cycle.
- Reg3 bit5 RC: hw_set -> first read 0x20, second read 0x0; read coincident with hw_set -> read returns 0x20 and the next read also returns 0x20.
- Reg4 RO=0xFF with hw_ro_in=0x3C plus a write 0xFF -> read 0x3C; write and read the same RW reg in the same cycle -> read returns the old value.

Source files
------------

// File: rtl/csr_reg_bank_pkg.sv
// Shared types and elaboration helpers for the CSR register bank.
package csr_reg_bank_pkg;

  localparam int unsigned MAX_DW   = 1024;
  localparam int unsigned MAX_STRB = MAX_DW / 8;

  typedef enum logic [2:0] {
    ACC_RW    = 3'd0,
    ACC_WO    = 3'd1,
    ACC_RO    = 3'd2,
    ACC_RC    = 3'd3,
    ACC_W1C   = 3'd4,
    ACC_PULSE = 3'd5
  } acc_type_e;

  typedef logic [MAX_DW-1:0]   dw_vec_t;
  typedef logic [MAX_STRB-1:0] strb_vec_t;

  function automatic dw_vec_t strb_to_mask(input strb_vec_t strb);
    dw_vec_t m;
    m = '0;
    for (int unsigned b = 0; b < MAX_STRB; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

  // True when any bit is claimed by more than one access type.
  function automatic logic masks_overlap(input dw_vec_t rw, input dw_vec_t wo,
                                         input dw_vec_t ro, input dw_vec_t rc,
                                         input dw_vec_t w1c, input dw_vec_t pulse);
    dw_vec_t seen;
    logic    ovl;
    seen = rw;
    ovl  = 1'b0;
    ovl  = ovl | (|(seen & wo));    seen = seen | wo;
    ovl  = ovl | (|(seen & ro));    seen = seen | ro;
    ovl  = ovl | (|(seen & rc));    seen = seen | rc;
    ovl  = ovl | (|(seen & w1c));   seen = seen | w1c;
    ovl  = ovl | (|(seen & pulse));
    return ovl;
  endfunction

endpackage

// File: rtl/csr_reg_bank_slice.sv
// One CSR register: per-bit access-type next-state logic and storage.
module csr_reg_bank_slice
  import csr_reg_bank_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RW_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] WO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RC_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] W1C_MASK   = '0,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] IRQ_MASK   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bmask,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] hw_ro,
  input  logic [DATA_WIDTH-1:0] hw_set,
  output logic [DATA_WIDTH-1:0] cfg,
  output logic [DATA_WIDTH-1:0] rd_val,
  output logic                  irq_src
);

  if (masks_overlap(dw_vec_t'(RW_MASK), dw_vec_t'(WO_MASK), dw_vec_t'(RO_MASK),
                    dw_vec_t'(RC_MASK), dw_vec_t'(W1C_MASK), dw_vec_t'(PULSE_MASK)))
  begin : g_bad_overlap
    $error("csr_reg_bank_slice: a bit is assigned more than one access type");
  end

  if (|(IRQ_MASK & ~W1C_MASK)) begin : g_bad_irq
    $error("csr_reg_bank_slice: IRQ_MASK must be a subset of W1C_MASK");
  end

  localparam logic [DATA_WIDTH-1:0] CFG_MASK  = RW_MASK | WO_MASK | PULSE_MASK;
  localparam logic [DATA_WIDTH-1:0] READ_MASK = RW_MASK | RC_MASK | W1C_MASK;

  logic [DATA_WIDTH-1:0] val_q;
  logic [DATA_WIDTH-1:0] val_d;
  logic [DATA_WIDTH-1:0] wr_hit;

  // hw_set is OR-ed in last for W1C/RC so a coincident clear never drops an event.
  always_comb begin
    wr_hit = wr_en ? wr_bmask : '0;
    val_d  = '0;
    val_d  = val_d | ((RW_MASK | WO_MASK) & ((wr_hit & wr_data) | (~wr_hit & val_q)));
    val_d  = val_d | (PULSE_MASK & wr_hit & wr_data);
    val_d  = val_d | (W1C_MASK & ((val_q & ~(wr_hit & wr_data)) | hw_set));
    val_d  = val_d | (RC_MASK & ((val_q & ~{DATA_WIDTH{rd_en}}) | hw_set));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  always_comb begin
    cfg     = val_q & CFG_MASK;
    rd_val  = (val_q & READ_MASK) | (hw_ro & RO_MASK);
    irq_src = |(val_q & IRQ_MASK);
  end

endmodule

// File: rtl/csr_reg_bank.sv
// CSR bank top: address decode, registered read response and interrupt reduction.
module csr_reg_bank
  import csr_reg_bank_pkg::*;
#(
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         NUM_REGS   = 8,
  parameter int unsigned                         ADDR_WIDTH = 3,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RW_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      WO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RC_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      W1C_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      IRQ_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic                           rd_req,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
  output logic                           irq
);

  if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
    $error("csr_reg_bank: DATA_WIDTH must be a non-zero multiple of 8");
  end

  if (NUM_REGS == 0 || ADDR_WIDTH > 30 || NUM_REGS > (1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("csr_reg_bank: ADDR_WIDTH too small for NUM_REGS");
  end

  logic [DATA_WIDTH-1:0] wr_bmask;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0]   rd_sel;
  logic [NUM_REGS-1:0]   irq_src;
  logic [DATA_WIDTH-1:0] rd_val [NUM_REGS];

  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q,   rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                  irq_q,      irq_d;

  always_comb begin
    wr_bmask = DATA_WIDTH'(strb_to_mask(MAX_STRB'(wr_strb)));
  end

  // Out-of-range indices match no slice, so they select nothing and have no side effects.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_req && (wr_addr == ADDR_WIDTH'(i));
      rd_sel[i] = rd_req && (rd_addr == ADDR_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    csr_reg_bank_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .RW_MASK    (RW_MASK   [g*DATA_WIDTH +: DATA_WIDTH]),
      .WO_MASK    (WO_MASK   [g*DATA_WIDTH +: DATA_WIDTH]),
      .RO_MASK    (RO_MASK   [g*DATA_WIDTH +: DATA_WIDTH]),
      .RC_MASK    (RC_MASK   [g*DATA_WIDTH +: DATA_WIDTH]),
      .W1C_MASK   (W1C_MASK  [g*DATA_WIDTH +: DATA_WIDTH]),
      .PULSE_MASK (PULSE_MASK[g*DATA_WIDTH +: DATA_WIDTH]),
      .IRQ_MASK   (IRQ_MASK  [g*DATA_WIDTH +: DATA_WIDTH])
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_sel[g]),
      .wr_data  (wr_data),
      .wr_bmask (wr_bmask),
      .rd_en    (rd_sel[g]),
      .hw_ro    (hw_ro_in [g*DATA_WIDTH +: DATA_WIDTH]),
      .hw_set   (hw_set_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .cfg      (cfg_out  [g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_val   (rd_val[g]),
      .irq_src  (irq_src[g])
    );
  end

  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rd_data_d = rd_data_d | (rd_sel[i] ? rd_val[i] : '0);
    end
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && !(|rd_sel);
    irq_d      = |irq_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rd_valid = rd_valid_q;
    rd_err   = rd_err_q;
    rd_data  = rd_data_q;
    irq      = irq_q;
  end

endmodule

// File: tb/tb_csr_reg_bank.sv
// Bench for csr_reg_bank: per-bit behavioural model, directed scenarios and random traffic.
module tb_csr_reg_bank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 4;

  // Register layouts, reg7 leftmost.
  localparam logic [NR*DW-1:0] RW_M = {32'h0000FFFF, 32'h00000000, 32'h0000FFFF, 32'hFFFFFF00,
                                       32'hFF000000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFFFF};
  localparam logic [NR*DW-1:0] WO_M = {32'h00000000, 32'hFFFFFFFF, 32'hE0000000, 32'h00000000,
                                       32'h00000000, 32'h00000000, 32'h0000FF00, 32'h00000000};
  localparam logic [NR*DW-1:0] RO_M = {32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h000000FF,
                                       32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
  localparam logic [NR*DW-1:0] RC_M = {32'h00000000, 32'h00000000, 32'h0F000000, 32'h00000000,
                                       32'h0000FF20, 32'h00000000, 32'h00000000, 32'h00000000};
  localparam logic [NR*DW-1:0] W1C_M = {32'h00000000, 32'h00000000, 32'h00FF0000, 32'h00000000,
                                        32'h00000000, 32'h000000F8, 32'h00000000, 32'h00000000};
  localparam logic [NR*DW-1:0] PUL_M = {32'h00000000, 32'h00000000, 32'h10000000, 32'h00000000,
                                        32'h00000000, 32'h00000000, 32'h000000FF, 32'h00000000};
  localparam logic [NR*DW-1:0] IRQ_M = {32'h00000000, 32'h00000000, 32'h00010000, 32'h00000000,
                                        32'h00000000, 32'h00000088, 32'h00000000, 32'h00000000};

  typedef enum int {T_NONE, T_RW, T_WO, T_RO, T_RC, T_W1C, T_PULSE} bit_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_req = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [DW/8-1:0]   wr_strb = '0;
  logic              rd_req = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              rd_err;
  logic [NR*DW-1:0]  hw_ro_in = '0;
  logic [NR*DW-1:0]  hw_set_in = '0;
  logic [NR*DW-1:0]  cfg_out;
  logic              irq;

  csr_reg_bank #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .RW_MASK    (RW_M),
    .WO_MASK    (WO_M),
    .RO_MASK    (RO_M),
    .RC_MASK    (RC_M),
    .W1C_MASK   (W1C_M),
    .PULSE_MASK (PUL_M),
    .IRQ_MASK   (IRQ_M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .hw_ro_in  (hw_ro_in),
    .hw_set_in (hw_set_in),
    .cfg_out   (cfg_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_val [NR];
  logic          e_valid, e_err, e_irq;
  logic [DW-1:0] e_data;
  bit            m_started = 0;

  function automatic bit_t kind(input int r, input int b);
    int idx;
    idx = r * DW + b;
    if (RW_M[idx])  return T_RW;
    if (WO_M[idx])  return T_WO;
    if (RO_M[idx])  return T_RO;
    if (RC_M[idx])  return T_RC;
    if (W1C_M[idx]) return T_W1C;
    if (PUL_M[idx]) return T_PULSE;
    return T_NONE;
  endfunction

  function automatic logic [DW-1:0] read_view(input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int b = 0; b < DW; b++) begin
      case (kind(r, b))
        T_RW, T_RC, T_W1C: v[b] = m_val[r][b];
        T_RO:              v[b] = hw_ro_in[r*DW + b];
        default:           v[b] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [NR*DW-1:0] cfg_view();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < DW; b++)
        if (kind(r, b) inside {T_RW, T_WO, T_PULSE}) v[r*DW + b] = m_val[r][b];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] nv [NR];
    logic          wr_hit, rd_hit, old, ev;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_val[r] = '0;
      e_valid = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_data = '0;
    end else begin
      e_irq = 1'b0;
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < DW; b++)
          if (IRQ_M[r*DW + b] && m_val[r][b]) e_irq = 1'b1;
      e_valid = rd_req;
      e_err   = rd_req && (int'(rd_addr) >= NR);
      e_data  = (rd_req && int'(rd_addr) < NR) ? read_view(int'(rd_addr)) : '0;
      for (int r = 0; r < NR; r++) begin
        for (int b = 0; b < DW; b++) begin
          wr_hit = wr_req && (int'(wr_addr) == r) && wr_strb[b/8];
          rd_hit = rd_req && (int'(rd_addr) == r);
          old    = m_val[r][b];
          ev     = hw_set_in[r*DW + b];
          case (kind(r, b))
            T_RW, T_WO: nv[r][b] = wr_hit ? wr_data[b] : old;
            T_PULSE:    nv[r][b] = wr_hit && wr_data[b];
            T_W1C:      nv[r][b] = ev || (old && !(wr_hit && wr_data[b]));
            T_RC:       nv[r][b] = ev || (old && !rd_hit);
            default:    nv[r][b] = 1'b0;
          endcase
        end
      end
      for (int r = 0; r < NR; r++) m_val[r] = nv[r];
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("rd_valid", {255'd0, rd_valid}, {255'd0, e_valid});
      check("rd_err",   {255'd0, rd_err},   {255'd0, e_err});
      if (e_valid) check("rd_data", {224'd0, rd_data}, {224'd0, e_data});
      check("cfg_out",  cfg_out, cfg_view());
      check("irq",      {255'd0, irq},      {255'd0, e_irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    wr_req = 1'b0; rd_req = 1'b0; hw_set_in = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle_in();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    wr_req = 1'b1; wr_addr = AW'(a); wr_data = d; wr_strb = s;
  endtask

  task automatic rd(input int a);
    rd_req = 1'b1; rd_addr = AW'(a);
  endtask

  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    check(name, {224'd0, act}, {224'd0, exp});
  endtask

  initial begin
    // A write presented during reset must be dropped.
    wr(0, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_in();
    lit("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_cfg", cfg_out, '0);
    lit("reset_valid", {31'd0, rd_valid}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      rd(i);
      tick();
      lit("rst_rd_valid", {31'd0, rd_valid}, 32'd1);
      lit("rst_rd_data", rd_data, 32'd0);
      lit("rst_rd_err", {31'd0, rd_err}, (i >= NR) ? 32'd1 : 32'd0);
    end

    wr(0, 32'h11111111, 4'hF); tick();
    lit("rw_cfg_full", cfg_out[31:0], 32'h11111111);
    wr(0, 32'hA5A5A5A5, 4'b0101); tick();
    lit("rw_cfg_strb", cfg_out[31:0], 32'h11A511A5);
    rd(0); tick();
    lit("rw_rd_strb", rd_data, 32'h11A511A5);

    wr(1, 32'h1, 4'h1); tick();
    lit("pulse_hi", {31'd0, cfg_out[32]}, 32'd1);
    tick();
    lit("pulse_lo", {31'd0, cfg_out[32]}, 32'd0);
    rd(1); tick();
    lit("pulse_rd", rd_data, 32'd0);
    wr(1, 32'h2, 4'h1); tick();
    lit("pulse_b2b_1", {31'd0, cfg_out[33]}, 32'd1);
    wr(1, 32'h2, 4'h1); tick();
    lit("pulse_b2b_2", {31'd0, cfg_out[33]}, 32'd1);
    tick();
    lit("pulse_b2b_end", {31'd0, cfg_out[33]}, 32'd0);

    hw_set_in[2*DW + 3] = 1'b1; tick();
    tick();
    lit("w1c_irq_set", {31'd0, irq}, 32'd1);
    wr(2, 32'h8, 4'h1); hw_set_in[2*DW + 3] = 1'b1; tick();
    tick();
    lit("w1c_setwins_irq", {31'd0, irq}, 32'd1);
    rd(2); tick();
    lit("w1c_setwins_rd", rd_data, 32'h8);
    wr(2, 32'h8, 4'h1); tick();
    tick();
    lit("w1c_clr_irq", {31'd0, irq}, 32'd0);
    rd(2); tick();
    lit("w1c_clr_rd", rd_data, 32'h0);

    hw_set_in[3*DW + 5] = 1'b1; tick();
    rd(3); tick();
    lit("rc_first", rd_data, 32'h20);
    rd(3); tick();
    lit("rc_second", rd_data, 32'h0);
    hw_set_in[3*DW + 5] = 1'b1; tick();
    rd(3); hw_set_in[3*DW + 5] = 1'b1; tick();
    lit("rc_setwins_1", rd_data, 32'h20);
    rd(3); tick();
    lit("rc_setwins_2", rd_data, 32'h20);
    rd(3); tick();
    lit("rc_setwins_3", rd_data, 32'h0);

    hw_ro_in[4*DW +: DW] = 32'h0000003C;
    wr(4, 32'hFF, 4'hF); tick();
    rd(4); tick();
    lit("ro_rd", rd_data, 32'h3C);
    wr(0, 32'hDEADBEEF, 4'hF); rd(0); tick();
    lit("rw_same_cycle_old", rd_data, 32'h11A511A5);
    wr(9, 32'hFFFFFFFF, 4'hF); rd(0); tick();
    lit("rw_same_cycle_new", rd_data, 32'hDEADBEEF);
    lit("oob_write_ignored", cfg_out[31:0], 32'hDEADBEEF);

    for (int n = 0; n < 3000; n++) begin
      rst     = (n == 1500);
      wr_req  = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 10));
      wr_data = $urandom;
      wr_strb = 4'($urandom);
      rd_req  = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 10));
      for (int r = 0; r < NR; r++) hw_set_in[r*DW +: DW] = $urandom & $urandom & $urandom;
      if (n % 16 == 0) for (int r = 0; r < NR; r++) hw_ro_in[r*DW +: DW] = $urandom;
      @(negedge clk);
    end
    rst = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
